// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART: register word offsets,
// STAT bit positions and the state encoding used by both serial FSMs.
package uart_pkg;

  localparam logic [1:0] UART_STAT = 2'd0;
  localparam logic [1:0] UART_RX   = 2'd1;
  localparam logic [1:0] UART_TX   = 2'd2;
  localparam logic [1:0] UART_IEN  = 2'd3;

  localparam int ST_RXEMPTY = 0;
  localparam int ST_RXFULL  = 1;
  localparam int ST_TXEMPTY = 2;
  localparam int ST_TXFULL  = 3;
  localparam int ST_TXOVF   = 4;
  localparam int ST_RXFERR  = 5;
  localparam int ST_RXOVF   = 6;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/uart_mmio_if.sv
// MMIO bus bundle for the UART plus read-only views of both FSM states.
// Handshake: bus_req is a one-cycle pulse, always accepted; bus_ack follows exactly one cycle later with bus_rdata valid.
interface uart_mmio_if;
  import uart_pkg::*;

  logic        bus_req;
  logic        bus_we;
  logic [1:0]  bus_addr;
  logic [3:0]  bus_wmask;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  uart_state_e dbg_tx_state;
  uart_state_e dbg_rx_state;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wmask, bus_wdata,
    input  bus_ack, bus_rdata, dbg_tx_state, dbg_rx_state
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wmask, bus_wdata,
    output bus_ack, bus_rdata, dbg_tx_state, dbg_rx_state
  );

endinterface

// File: rtl/uart_fifo.sv
// Synchronous FIFO with show-ahead head data. Pointers carry one extra
// bit so full and empty are distinguishable; callers gate push/pop.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign rdata = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_mmio.sv
// Memory-mapped UART: STAT/RX/TX registers, TX and RX FIFOs, serial FSMs.
// Optional UART_IRQ_EN adds an interrupt-enable register at word offset 3.
module uart_mmio
  import uart_pkg::*;
#(
  parameter int CLK_DIV   = 16,
  parameter int DATA_BITS = 8,
  parameter int TX_DEPTH  = 8,
  parameter int RX_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        rst,
  uart_mmio_if.slave  bus,
  input  logic        uart_rxd,
  output logic        uart_txd,
  output logic        irq
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] DIV_HALF = CW'(CLK_DIV / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  logic rd_stb, wr_stb, stat_rd, rx_rd, tx_wr;
  assign rd_stb  = bus.bus_req & ~bus.bus_we;
  assign wr_stb  = bus.bus_req &  bus.bus_we;
  assign stat_rd = rd_stb && (bus.bus_addr == UART_STAT);
  assign rx_rd   = rd_stb && (bus.bus_addr == UART_RX);
  assign tx_wr   = wr_stb && (bus.bus_addr == UART_TX) && bus.bus_wmask[0];

  // ---------------- TX path ----------------
  uart_state_e          tx_state, tx_next;
  logic [CW-1:0]        tx_cnt;
  logic [BW-1:0]        tx_bit;
  logic [DATA_BITS-1:0] tx_shift, tx_head;
  logic tx_full, tx_empty, tx_push, tx_pop, tx_ovf_set, tx_baud_done, tx_idle_empty;

  assign tx_baud_done  = (tx_cnt == DIV_LAST);
  assign tx_pop        = ~tx_empty & ((tx_state == S_IDLE) | ((tx_state == S_STOP) & tx_baud_done));
  // A full FIFO still accepts a write when the FSM pops in the same cycle.
  assign tx_push       = tx_wr & (~tx_full | tx_pop);
  assign tx_ovf_set    = tx_wr & tx_full & ~tx_pop;
  assign tx_idle_empty = tx_empty & (tx_state == S_IDLE);

  uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(tx_push), .wdata(bus.bus_wdata[DATA_BITS-1:0]),
    .pop(tx_pop), .rdata(tx_head), .full(tx_full), .empty(tx_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tx_state <= S_IDLE;
    else     tx_state <= tx_next;
  end

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      S_IDLE:  if (!tx_empty) tx_next = S_START;
      S_START: if (tx_baud_done) tx_next = S_DATA;
      S_DATA:  if (tx_baud_done && tx_bit == BIT_LAST) tx_next = S_STOP;
      S_STOP:  if (tx_baud_done) tx_next = tx_empty ? S_IDLE : S_START;
      default: tx_next = S_IDLE;
    endcase
  end

  // Decoded straight from state so an asynchronous reset raises the line at once.
  always_comb begin
    uart_txd = 1'b1;
    case (tx_state)
      S_START: uart_txd = 1'b0;
      S_DATA:  uart_txd = tx_shift[0];
      default: uart_txd = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
    end else begin
      if (tx_state == S_IDLE || tx_next != tx_state || tx_baud_done) tx_cnt <= '0;
      else tx_cnt <= tx_cnt + 1'b1;
      if (tx_pop) tx_shift <= tx_head;
      else if (tx_state == S_DATA && tx_baud_done) tx_shift <= tx_shift >> 1;
      if (tx_state != S_DATA) tx_bit <= '0;
      else if (tx_baud_done) tx_bit <= tx_bit + 1'b1;
    end
  end

  // ---------------- RX path ----------------
  uart_state_e          rx_state, rx_next;
  logic [CW-1:0]        rx_cnt;
  logic [BW-1:0]        rx_bit;
  logic [DATA_BITS-1:0] rx_shift, rx_head;
  logic rx_meta, rxs, rx_full, rx_empty, rx_push, rx_pop, rx_ferr_set, rx_ovf_set;
  logic rx_baud_done, rx_half;

  assign rx_baud_done = (rx_cnt == DIV_LAST);
  assign rx_half      = (rx_cnt == DIV_HALF);
  assign rx_pop       = rx_rd & ~rx_empty;

  uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_push), .wdata(rx_shift),
    .pop(rx_pop), .rdata(rx_head), .full(rx_full), .empty(rx_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta  <= 1'b1;
      rxs      <= 1'b1;
      rx_state <= S_IDLE;
    end else begin
      rx_meta  <= uart_rxd;
      rxs      <= rx_meta;
      rx_state <= rx_next;
    end
  end

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      S_IDLE:  if (!rxs) rx_next = S_START;
      S_START: if (rx_half) rx_next = rxs ? S_IDLE : S_DATA;
      S_DATA:  if (rx_baud_done && rx_bit == BIT_LAST) rx_next = S_STOP;
      S_STOP:  if (rx_baud_done) rx_next = S_IDLE;
      default: rx_next = S_IDLE;
    endcase
  end

  always_comb begin
    rx_push     = 1'b0;
    rx_ferr_set = 1'b0;
    rx_ovf_set  = 1'b0;
    if (rx_state == S_STOP && rx_baud_done) begin
      if (!rxs)         rx_ferr_set = 1'b1;
      else if (rx_full) rx_ovf_set  = 1'b1;
      else              rx_push     = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      if (rx_state == S_IDLE || rx_next != rx_state || rx_baud_done) rx_cnt <= '0;
      else rx_cnt <= rx_cnt + 1'b1;
      if (rx_state == S_DATA && rx_baud_done) rx_shift <= {rxs, rx_shift[DATA_BITS-1:1]};
      if (rx_state != S_DATA) rx_bit <= '0;
      else if (rx_baud_done) rx_bit <= rx_bit + 1'b1;
    end
  end

  // ---------------- Registers and bus ----------------
  logic        tx_ovf, rx_ferr, rx_ovf;
  logic [31:0] stat_word, rdata_d;
  logic [1:0]  ien;

  // Sticky flags: a set in the same cycle as the clearing STAT read wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_ovf  <= 1'b0;
      rx_ferr <= 1'b0;
      rx_ovf  <= 1'b0;
    end else begin
      tx_ovf  <= tx_ovf_set  | (tx_ovf  & ~stat_rd);
      rx_ferr <= rx_ferr_set | (rx_ferr & ~stat_rd);
      rx_ovf  <= rx_ovf_set  | (rx_ovf  & ~stat_rd);
    end
  end

  always_comb begin
    stat_word             = '0;
    stat_word[ST_RXEMPTY] = rx_empty;
    stat_word[ST_RXFULL]  = rx_full;
    stat_word[ST_TXEMPTY] = tx_idle_empty;
    stat_word[ST_TXFULL]  = tx_full;
    stat_word[ST_TXOVF]   = tx_ovf;
    stat_word[ST_RXFERR]  = rx_ferr;
    stat_word[ST_RXOVF]   = rx_ovf;
  end

`ifdef UART_IRQ_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ien <= '0;
      irq <= 1'b0;
    end else begin
      if (wr_stb && bus.bus_addr == UART_IEN && bus.bus_wmask[0]) ien <= bus.bus_wdata[1:0];
      irq <= (ien[0] & ~rx_empty) | (ien[1] & tx_idle_empty);
    end
  end
`else
  assign ien = 2'b00;
  assign irq = 1'b0;
`endif

  always_comb begin
    rdata_d = '0;
    if (rd_stb) begin
      case (bus.bus_addr)
        UART_STAT: rdata_d = stat_word;
        UART_RX:   if (!rx_empty) rdata_d = 32'(rx_head);
`ifdef UART_IRQ_EN
        UART_IEN:  rdata_d = {30'b0, ien};
`endif
        default:   rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.bus_ack   <= 1'b0;
      bus.bus_rdata <= '0;
    end else begin
      bus.bus_ack   <= bus.bus_req;
      bus.bus_rdata <= rdata_d;
    end
  end

  assign bus.dbg_tx_state = tx_state;
  assign bus.dbg_rx_state = rx_state;

  logic unused_bits;
  assign unused_bits = &{1'b0, bus.bus_wdata[31:DATA_BITS], bus.bus_wmask[3:1], ien};

endmodule

// File: tb/tb_uart_mmio.sv
// Directed bench for uart_mmio: register table, TX/RX serial frames, overflow,
// framing error, glitch rejection, reset mid-frame and (with UART_IRQ_EN) irq.
module tb_uart_mmio;
  import uart_pkg::*;

  localparam int CLK_DIV   = 16;
  localparam int DATA_BITS = 8;
  localparam int TX_DEPTH  = 8;
  localparam int RX_DEPTH  = 8;
  localparam int FRAME     = (DATA_BITS + 2) * CLK_DIV;
`ifdef UART_IRQ_EN
  localparam logic [31:0] IEN_RB = 32'h3;
`else
  localparam logic [31:0] IEN_RB = 32'h0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic uart_rxd = 1'b1;
  logic uart_txd, irq;

  always #5 clk = ~clk;

  uart_mmio_if bus ();

  uart_mmio #(.CLK_DIV(CLK_DIV), .DATA_BITS(DATA_BITS), .TX_DEPTH(TX_DEPTH), .RX_DEPTH(RX_DEPTH)) dut (
    .clk(clk), .rst(rst), .bus(bus), .uart_rxd(uart_rxd), .uart_txd(uart_txd), .irq(irq)
  );

  // ---------------- scoreboard ----------------
  int tests_run    = 0;
  int tests_failed = 0;
  logic [DATA_BITS-1:0] exp_q[$];

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_xfer(input logic we, input logic [1:0] addr, input logic [3:0] wmask,
                          input logic [31:0] wdata, output logic [31:0] rdata);
    tick(1);
    bus.bus_req   = 1'b1;
    bus.bus_we    = we;
    bus.bus_addr  = addr;
    bus.bus_wmask = wmask;
    bus.bus_wdata = wdata;
    tick(1);
    bus.bus_req   = 1'b0;
    bus.bus_we    = 1'b0;
    check("bus_ack", 32'(bus.bus_ack), 32'h1);
    rdata = bus.bus_rdata;
  endtask

  task automatic bus_read(input logic [1:0] addr, input string name, input logic [31:0] exp);
    logic [31:0] r;
    bus_xfer(1'b0, addr, 4'h0, 32'h0, r);
    check(name, r, exp);
  endtask

  task automatic bus_write(input logic [1:0] addr, input logic [3:0] wmask, input logic [31:0] wdata);
    logic [31:0] r;
    bus_xfer(1'b1, addr, wmask, wdata, r);
  endtask

  // Records one full TX frame starting at the first low sample.
  task automatic tx_frame(output logic [DATA_BITS-1:0] data, output int low_run, output logic stop_ok);
    logic line [FRAME];
    int budget;
    bit leading;
    budget  = 4 * FRAME;
    data    = '0;
    low_run = 0;
    stop_ok = 1'b0;
    while (uart_txd !== 1'b0 && budget > 0) begin
      tick(1);
      budget--;
    end
    if (uart_txd !== 1'b0) begin
      check("tx_start_timeout", 32'(uart_txd), 32'h0);
      return;
    end
    for (int j = 0; j < FRAME; j++) begin
      line[j] = uart_txd;
      if (j < FRAME - 1) tick(1);
    end
    leading = 1'b1;
    for (int j = 0; j < FRAME; j++) begin
      if (leading && line[j] == 1'b0) low_run++;
      else leading = 1'b0;
    end
    for (int i = 0; i < DATA_BITS; i++) data[i] = line[CLK_DIV / 2 - 1 + CLK_DIV * (i + 1)];
    stop_ok = 1'b1;
    for (int j = CLK_DIV * (DATA_BITS + 1); j < FRAME; j++) if (line[j] !== 1'b1) stop_ok = 1'b0;
  endtask

  task automatic rx_send(input logic [DATA_BITS-1:0] data, input logic stop_bit);
    uart_rxd = 1'b0;
    tick(CLK_DIV);
    for (int i = 0; i < DATA_BITS; i++) begin
      uart_rxd = data[i];
      tick(CLK_DIV);
    end
    uart_rxd = stop_bit;
    tick(CLK_DIV);
    uart_rxd = 1'b1;
    tick(2);
  endtask

  // ---------------- register table ----------------
  typedef struct {
    logic        we;
    logic [1:0]  addr;
    logic [3:0]  wmask;
    logic [31:0] wdata;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs [12];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DATA_BITS-1:0] d;
    int lr;
    logic so;
    logic [31:0] r;

    vecs[0]  = '{1'b0, UART_STAT, 4'h0, 32'h0,        32'h5,  "stat_reset"};
    vecs[1]  = '{1'b0, UART_RX,   4'h0, 32'h0,        32'h0,  "rx_read_empty"};
    vecs[2]  = '{1'b1, UART_STAT, 4'hF, 32'hFFFF_FFFF, 32'h0, "stat_write"};
    vecs[3]  = '{1'b0, UART_STAT, 4'h0, 32'h0,        32'h5,  "stat_after_stat_wr"};
    vecs[4]  = '{1'b1, UART_RX,   4'hF, 32'h0000_00FF, 32'h0, "rx_write"};
    vecs[5]  = '{1'b0, UART_TX,   4'h0, 32'h0,        32'h0,  "tx_read_zero"};
    vecs[6]  = '{1'b1, UART_IEN,  4'hF, 32'hFFFF_FFFF, 32'h0, "off3_write"};
    vecs[7]  = '{1'b0, UART_IEN,  4'h0, 32'h0,        IEN_RB, "off3_read"};
    vecs[8]  = '{1'b1, UART_IEN,  4'hF, 32'h0,        32'h0,  "off3_clear"};
    vecs[9]  = '{1'b1, UART_TX,   4'hE, 32'h0000_0055, 32'h0, "tx_write_mask0_off"};
    vecs[10] = '{1'b0, UART_STAT, 4'h0, 32'h0,        32'h5,  "stat_no_push"};
    vecs[11] = '{1'b0, UART_RX,   4'h0, 32'h0,        32'h0,  "rx_read_empty2"};

    bus.bus_req   = 1'b0;
    bus.bus_we    = 1'b0;
    bus.bus_addr  = 2'd0;
    bus.bus_wmask = 4'h0;
    bus.bus_wdata = 32'h0;

    // Reset values
    tick(3);
    check("rst_ack",      32'(bus.bus_ack),      32'h0);
    check("rst_rdata",    bus.bus_rdata,         32'h0);
    check("rst_txd",      32'(uart_txd),         32'h1);
    check("rst_irq",      32'(irq),              32'h0);
    check("rst_tx_state", 32'(bus.dbg_tx_state), 32'(S_IDLE));
    check("rst_rx_state", 32'(bus.dbg_rx_state), 32'(S_IDLE));
    rst = 1'b0;
    tick(2);

    for (int i = 0; i < 12; i++) begin
      bus_xfer(vecs[i].we, vecs[i].addr, vecs[i].wmask, vecs[i].wdata, r);
      if (!vecs[i].we) check(vecs[i].name, r, vecs[i].exp);
    end
    tick(2);
    check("txd_idle", 32'(uart_txd), 32'h1);

    // Single TX character 0x41
    exp_q.push_back(8'h41);
    bus_write(UART_TX, 4'h1, 32'h41);
    fork
      tx_frame(d, lr, so);
      begin
        tick(40);
        bus_read(UART_STAT, "stat_mid_frame", 32'h1);
      end
    join
    check("tx_start_len", 32'(lr), 32'(CLK_DIV));
    check("tx_data_41", 32'(d), 32'(exp_q.pop_front()));
    check("tx_stop_41", 32'(so), 32'h1);
    tick(4);
    bus_read(UART_STAT, "stat_after_frame", 32'h5);

    // Back-to-back writes overflow the TX FIFO on the tenth write
    fork
      begin
        for (int f = 0; f < TX_DEPTH + 1; f++) begin
          tx_frame(d, lr, so);
          check("tx_b2b_data", 32'(d), 32'(exp_q.pop_front()));
          check("tx_b2b_stop", 32'(so), 32'h1);
        end
      end
      begin
        for (int i = 0; i < TX_DEPTH + 1; i++) exp_q.push_back(DATA_BITS'(8'h10 + i));
        tick(1);
        for (int i = 0; i < TX_DEPTH + 2; i++) begin
          bus.bus_req   = 1'b1;
          bus.bus_we    = 1'b1;
          bus.bus_addr  = UART_TX;
          bus.bus_wmask = 4'h1;
          bus.bus_wdata = 32'h10 + 32'(i);
          tick(1);
          check("b2b_ack", 32'(bus.bus_ack), 32'h1);
        end
        bus.bus_req = 1'b0;
        bus.bus_we  = 1'b0;
        bus_read(UART_STAT, "stat_txovf", 32'h19);
        bus_read(UART_STAT, "stat_txovf_clr", 32'h09);
      end
    join
    check("tx_exp_q_drained", 32'(exp_q.size()), 32'h0);
    tick(4);
    bus_read(UART_STAT, "stat_tx_drained", 32'h5);
    tick(FRAME);
    check("txd_no_dropped_frame", 32'(uart_txd), 32'h1);

    // RX 0xA5
    rx_send(8'hA5, 1'b1);
    tick(2);
    bus_read(UART_STAT, "stat_rx_avail", 32'h4);
`ifndef UART_IRQ_EN
    check("irq_tied_low", 32'(irq), 32'h0);
`endif
    bus_read(UART_RX, "rx_data_a5", 32'hA5);
    bus_read(UART_RX, "rx_read_after_pop", 32'h0);
    bus_read(UART_STAT, "stat_rx_drained", 32'h5);

    // Framing error
    rx_send(8'h3C, 1'b0);
    tick(CLK_DIV);
    bus_read(UART_STAT, "stat_rxferr", 32'h25);
    bus_read(UART_STAT, "stat_rxferr_clr", 32'h5);
    bus_read(UART_RX, "rx_ferr_discarded", 32'h0);

    // 4-cycle glitch
    uart_rxd = 1'b0;
    tick(4);
    uart_rxd = 1'b1;
    tick(FRAME + CLK_DIV);
    bus_read(UART_STAT, "stat_glitch", 32'h5);

    // RX overflow: ninth character dropped
    for (int i = 0; i < RX_DEPTH + 1; i++) rx_send(DATA_BITS'(8'h60 + i), 1'b1);
    tick(2);
    bus_read(UART_STAT, "stat_rxovf", 32'h46);
    for (int i = 0; i < RX_DEPTH; i++) bus_read(UART_RX, "rx_fifo_order", 32'h60 + 32'(i));
    bus_read(UART_RX, "rx_after_ovf_empty", 32'h0);
    bus_read(UART_STAT, "stat_after_ovf", 32'h5);

    // Reset in the middle of a TX frame
    bus_write(UART_TX, 4'h1, 32'h00);
    tick(CLK_DIV + 4);
    check("txd_mid_frame", 32'(uart_txd), 32'h0);
    rst = 1'b1;
    #1;
    check("txd_async_reset", 32'(uart_txd), 32'h1);
    check("tx_state_async_reset", 32'(bus.dbg_tx_state), 32'(S_IDLE));
    tick(2);
    rst = 1'b0;
    tick(2);
    bus_read(UART_STAT, "stat_after_reset", 32'h5);
    tick(FRAME);
    check("txd_after_reset", 32'(uart_txd), 32'h1);

`ifdef UART_IRQ_EN
    bus_write(UART_IEN, 4'h1, 32'h1);
    tick(2);
    check("irq_rx_empty", 32'(irq), 32'h0);
    rx_send(8'h5A, 1'b1);
    tick(2);
    check("irq_rx_ready", 32'(irq), 32'h1);
    bus_read(UART_RX, "irq_rx_data", 32'h5A);
    check("irq_same_cycle", 32'(irq), 32'h1);
    tick(1);
    check("irq_cleared", 32'(irq), 32'h0);
    bus_write(UART_IEN, 4'h1, 32'h2);
    tick(2);
    check("irq_tx_empty", 32'(irq), 32'h1);
    bus_write(UART_IEN, 4'h1, 32'h0);
    tick(2);
    check("irq_disabled", 32'(irq), 32'h0);
    bus_read(UART_IEN, "ien_readback", 32'h0);
`else
    check("irq_default_build", 32'(irq), 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
